tetris_render: RTL and testbench

TETRIS_RENDER -- requirements
Module: tetris_render

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/tetris_palette.sv | 24 ++
 rtl/tetris_render.sv | 177 +++++++++++++++++
 tb/tb_tetris_render.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared geometry, colour types and palette constants for the tetris renderer.
package tetris_pkg;
  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int CELL_LOG2 = 4;
  localparam int BORDER_PX = 4;

  typedef logic [2:0]  color_t;
  typedef logic [11:0] rgb_t;

  localparam rgb_t RGB_BLACK  = 12'h000;
  localparam rgb_t RGB_WHITE  = 12'hFFF;
  localparam rgb_t RGB_GRID   = 12'h222;
  localparam rgb_t RGB_BORDER = 12'h888;

  localparam rgb_t PAL_CYAN    = 12'h0FF;
  localparam rgb_t PAL_YELLOW  = 12'hFF0;
  localparam rgb_t PAL_MAGENTA = 12'hF0F;
  localparam rgb_t PAL_GREEN   = 12'h0F0;
  localparam rgb_t PAL_RED     = 12'hF00;
  localparam rgb_t PAL_BLUE    = 12'h00F;
  localparam rgb_t PAL_ORANGE  = 12'hF80;
endpackage

// File: rtl/tetris_palette.sv
// Colour code to 12-bit RGB lookup; code 0 is empty and renders black.
module tetris_palette
  import tetris_pkg::*;
(
  input  color_t code,
  output rgb_t   rgb
);

  // code-to-colour table
  always_comb begin
    rgb = RGB_BLACK;
    case (code)
      3'd1:    rgb = PAL_CYAN;
      3'd2:    rgb = PAL_YELLOW;
      3'd3:    rgb = PAL_MAGENTA;
      3'd4:    rgb = PAL_GREEN;
      3'd5:    rgb = PAL_RED;
      3'd6:    rgb = PAL_BLUE;
      3'd7:    rgb = PAL_ORANGE;
      default: rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/tetris_render.sv
// Two-stage pixel pipeline drawing the board, falling piece, line-clear flash and border.
module tetris_render
  import tetris_pkg::*;
#(
  parameter int X0 = 240,
  parameter int Y0 = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [7:0]  board_raddr,
  input  logic [2:0]  board_rdata,
  input  logic        piece_valid,
  input  logic [19:0] piece_rows,
  input  logic [15:0] piece_cols,
  input  logic [2:0]  piece_color,
  input  logic [19:0] clear_rows,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        video_on_out
);

  localparam int         BW   = COLS << CELL_LOG2;
  localparam int         BH   = ROWS << CELL_LOG2;
  localparam logic [9:0] X0_V = 10'(X0);
  localparam logic [9:0] Y0_V = 10'(Y0);

  logic [9:0] dx_s, dy_s;
  logic       in_board_s, border_s, grid_s, clear_s;
  logic [4:0] row_s;
  logic [3:0] col_s;
  logic [7:0] addr_s;

  logic       s1_in_board_r, s1_border_r, s1_grid_r, s1_clear_r;
  logic       s1_video_on_r, s1_hsync_r, s1_vsync_r;
  logic [4:0] s1_row_r;
  logic [3:0] s1_col_r;

  logic        sh_valid_r;
  logic [19:0] sh_rows_r;
  logic [15:0] sh_cols_r;
  color_t      sh_color_r;
  logic [5:0]  frame_cnt_r;
  logic        frame_start_s;

  logic   piece_hit_s;
  color_t pal_code_s;
  rgb_t   pal_rgb_s, rgb_s;

  // stage-1 geometry: cell coordinates, region flags and RAM address
  always_comb begin
    dx_s       = x - X0_V;
    dy_s       = y - Y0_V;
    in_board_s = (int'(x) >= X0) && (int'(x) < X0 + BW) &&
                 (int'(y) >= Y0) && (int'(y) < Y0 + BH);
    border_s   = !in_board_s &&
                 (int'(x) >= X0 - BORDER_PX) && (int'(x) < X0 + BW + BORDER_PX) &&
                 (int'(y) >= Y0 - BORDER_PX) && (int'(y) < Y0 + BH + BORDER_PX);
    row_s      = dy_s[CELL_LOG2 +: 5];
    col_s      = dx_s[CELL_LOG2 +: 4];
    grid_s     = (dx_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                 (dy_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}});
    if (in_board_s) begin
      addr_s  = 8'(row_s) * 8'(COLS) + 8'(col_s);
      clear_s = clear_rows[row_s];
    end else begin
      addr_s  = 8'd0;
      clear_s = 1'b0;
    end
  end

  // a new frame begins when the registered vsync falls
  assign frame_start_s = p_tick && s1_vsync_r && !vsync;

  // stage-1 registers plus frame-synchronous piece shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_row_r      <= 5'd0;
      s1_col_r      <= 4'd0;
      s1_in_board_r <= 1'b0;
      s1_border_r   <= 1'b0;
      s1_grid_r     <= 1'b0;
      s1_clear_r    <= 1'b0;
      s1_video_on_r <= 1'b0;
      s1_hsync_r    <= 1'b1;
      s1_vsync_r    <= 1'b1;
      board_raddr   <= 8'd0;
      frame_cnt_r   <= 6'd0;
      sh_valid_r    <= 1'b0;
      sh_rows_r     <= 20'd0;
      sh_cols_r     <= 16'd0;
      sh_color_r    <= 3'd0;
    end else if (p_tick) begin
      s1_row_r      <= row_s;
      s1_col_r      <= col_s;
      s1_in_board_r <= in_board_s;
      s1_border_r   <= border_s;
      s1_grid_r     <= grid_s;
      s1_clear_r    <= clear_s;
      s1_video_on_r <= video_on;
      s1_hsync_r    <= hsync;
      s1_vsync_r    <= vsync;
      board_raddr   <= addr_s;
      if (frame_start_s) begin
        frame_cnt_r <= frame_cnt_r + 6'd1;
        sh_valid_r  <= piece_valid;
        sh_rows_r   <= piece_rows;
        sh_cols_r   <= piece_cols;
        sh_color_r  <= piece_color;
      end
    end
  end

  // piece cell match; off-board cell coordinates never match
  always_comb begin
    piece_hit_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      piece_hit_s = piece_hit_s |
                    ((sh_rows_r[i*5 +: 5] == s1_row_r) && (sh_cols_r[i*4 +: 4] == s1_col_r) &&
                     (int'(sh_rows_r[i*5 +: 5]) < ROWS) && (int'(sh_cols_r[i*4 +: 4]) < COLS));
    end
    piece_hit_s = piece_hit_s && sh_valid_r && s1_in_board_r;
  end

  assign pal_code_s = piece_hit_s ? sh_color_r : board_rdata;

  tetris_palette u_palette (
    .code (pal_code_s),
    .rgb  (pal_rgb_s)
  );

  // stage-2 colour priority
  always_comb begin
    rgb_s = RGB_BLACK;
    if (!s1_video_on_r) begin
      rgb_s = RGB_BLACK;
    end else if (s1_in_board_r) begin
      if (piece_hit_s) begin
        rgb_s = pal_rgb_s;
      end else if (s1_clear_r && frame_cnt_r[3]) begin
        rgb_s = RGB_WHITE;
      end else if (board_rdata != 3'd0) begin
        rgb_s = pal_rgb_s;
      end else if (s1_grid_r) begin
        rgb_s = RGB_GRID;
      end else begin
        rgb_s = RGB_BLACK;
      end
    end else if (s1_border_r) begin
      rgb_s = RGB_BORDER;
    end else begin
      rgb_s = RGB_BLACK;
    end
  end

  // stage-2 output registers, syncs delayed alongside the colour
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb          <= RGB_BLACK;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
      video_on_out <= 1'b0;
    end else if (p_tick) begin
      rgb          <= rgb_s;
      hsync_out    <= s1_hsync_r;
      vsync_out    <= s1_vsync_r;
      video_on_out <= s1_video_on_r;
    end
  end

endmodule

// File: tb/tb_tetris_render.sv
// Table-driven bench for tetris_render with a two-deep expected-output scoreboard.
module tb_tetris_render;

  logic        clk = 1'b0;
  logic        reset, p_tick, video_on, hsync, vsync;
  logic [9:0]  x, y;
  logic [7:0]  board_raddr;
  logic [2:0]  board_rdata;
  logic        piece_valid;
  logic [19:0] piece_rows;
  logic [15:0] piece_cols;
  logic [2:0]  piece_color;
  logic [19:0] clear_rows;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, video_on_out;

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs, vo;
    string       nm;
  } exp_t;

  typedef struct {
    int          px, py;
    bit          vo, hs, vs;
    logic [11:0] rgb;
    int          addr;
    string       nm;
  } vec_t;

  exp_t        q[$];
  vec_t        vt[$];
  logic [2:0]  board_mem [0:255];
  logic [5:0]  fc;
  bit          last_vs;
  int          total = 0;
  int          bad = 0;

  tetris_render #(.X0(240), .Y0(80)) dut (
    .clk          (clk),
    .reset        (reset),
    .p_tick       (p_tick),
    .video_on     (video_on),
    .hsync        (hsync),
    .vsync        (vsync),
    .x            (x),
    .y            (y),
    .board_raddr  (board_raddr),
    .board_rdata  (board_rdata),
    .piece_valid  (piece_valid),
    .piece_rows   (piece_rows),
    .piece_cols   (piece_cols),
    .piece_color  (piece_color),
    .clear_rows   (clear_rows),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .video_on_out (video_on_out)
  );

  always #5 clk = ~clk;

  // board RAM model: one-clock read latency
  always @(posedge clk) board_rdata <= board_mem[board_raddr];

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push_inactive();
    exp_t e;
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.vo = 1'b0; e.nm = "post_reset";
    q.push_back(e);
  endtask

  // one pixel per p_tick; output for a pixel appears after the second p_tick
  task automatic pix(input int px, input int py, input bit vo, input bit hs, input bit vs,
                     input logic [11:0] er, input int ea, input string nm);
    exp_t e;
    x = 10'(px); y = 10'(py); video_on = vo; hsync = hs; vsync = vs;
    if (last_vs && !vs) fc = fc + 6'd1;
    last_vs = vs;
    e.rgb = er; e.hs = hs; e.vs = vs; e.vo = vo; e.nm = nm;
    q.push_back(e);
    @(negedge clk); p_tick = 1'b1;
    @(posedge clk); #1; p_tick = 1'b0;
    if (ea >= 0) chk({nm, "_addr"}, {4'd0, board_raddr}, 12'(ea));
    if (q.size() == 2) begin
      e = q.pop_front();
      chk({e.nm, "_rgb"}, rgb, e.rgb);
      chk({e.nm, "_hs"}, {11'd0, hsync_out}, {11'd0, e.hs});
      chk({e.nm, "_vs"}, {11'd0, vsync_out}, {11'd0, e.vs});
      chk({e.nm, "_vo"}, {11'd0, video_on_out}, {11'd0, e.vo});
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) board_mem[i] = 3'd0;
    board_mem[0]  = 3'd3;
    board_mem[1]  = 3'd1;
    board_mem[2]  = 3'd2;
    board_mem[3]  = 3'd4;
    board_mem[4]  = 3'd6;
    board_mem[7]  = 3'd7;
    board_mem[54] = 3'd2;

    // cells: (5,4), (25,4) off-board row, (5,12) off-board col, (5,4) duplicate
    piece_valid = 1'b1;
    piece_rows  = {5'd5, 5'd5, 5'd25, 5'd5};
    piece_cols  = {4'd4, 4'd12, 4'd4, 4'd4};
    piece_color = 3'd5;
    clear_rows  = 20'd0;
    x = 10'd0; y = 10'd0; video_on = 1'b1; hsync = 1'b0; vsync = 1'b0;

    vt.push_back('{0,   0,   1'b0, 1'b1, 1'b0, 12'h000, 0,   "vs_fall"});
    vt.push_back('{240, 80,  1'b1, 1'b0, 1'b0, 12'hF0F, 0,   "cell00"});
    vt.push_back('{310, 165, 1'b1, 1'b1, 1'b0, 12'hF00, 54,  "piece_over"});
    vt.push_back('{250, 100, 1'b1, 1'b1, 1'b0, 12'h000, 10,  "empty"});
    vt.push_back('{256, 100, 1'b1, 1'b0, 1'b0, 12'h222, 11,  "grid_x"});
    vt.push_back('{250, 96,  1'b1, 1'b1, 1'b0, 12'h222, 10,  "grid_y"});
    vt.push_back('{260, 85,  1'b1, 1'b1, 1'b0, 12'h0FF, 1,   "pal1"});
    vt.push_back('{276, 85,  1'b1, 1'b0, 1'b0, 12'hFF0, 2,   "pal2"});
    vt.push_back('{292, 85,  1'b1, 1'b1, 1'b0, 12'h0F0, 3,   "pal4"});
    vt.push_back('{308, 85,  1'b1, 1'b1, 1'b0, 12'h00F, 4,   "pal6"});
    vt.push_back('{355, 85,  1'b1, 1'b0, 1'b0, 12'hF80, 7,   "pal7"});
    vt.push_back('{399, 399, 1'b1, 1'b1, 1'b0, 12'h000, 199, "last_cell"});
    vt.push_back('{238, 200, 1'b1, 1'b1, 1'b0, 12'h888, 0,   "border_l"});
    vt.push_back('{236, 200, 1'b1, 1'b1, 1'b0, 12'h888, 0,   "border_l_edge"});
    vt.push_back('{235, 200, 1'b1, 1'b0, 1'b0, 12'h000, 0,   "outside_l"});
    vt.push_back('{230, 200, 1'b1, 1'b1, 1'b0, 12'h000, 0,   "outside"});
    vt.push_back('{403, 200, 1'b1, 1'b1, 1'b0, 12'h888, 0,   "border_r"});
    vt.push_back('{404, 200, 1'b1, 1'b1, 1'b0, 12'h000, 0,   "outside_r"});
    vt.push_back('{300, 403, 1'b1, 1'b0, 1'b0, 12'h888, 0,   "border_b"});
    vt.push_back('{300, 404, 1'b1, 1'b1, 1'b0, 12'h000, 0,   "outside_b"});
    vt.push_back('{300, 76,  1'b1, 1'b1, 1'b0, 12'h888, 0,   "border_t"});
    vt.push_back('{300, 75,  1'b1, 1'b1, 1'b0, 12'h000, 0,   "outside_t"});
    vt.push_back('{236, 76,  1'b1, 1'b1, 1'b0, 12'h888, 0,   "border_corner"});
    vt.push_back('{240, 80,  1'b0, 1'b1, 1'b0, 12'h000, 0,   "vo_off"});
    vt.push_back('{310, 165, 1'b0, 1'b0, 1'b0, 12'h000, 54,  "vo_off_piece"});
    vt.push_back('{238, 200, 1'b0, 1'b1, 1'b0, 12'h000, 0,   "vo_off_border"});

    // reset held with p_tick high must still win
    reset = 1'b1; p_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync", {11'd0, hsync_out}, 12'd1);
    chk("rst_vsync", {11'd0, vsync_out}, 12'd1);
    chk("rst_vo", {11'd0, video_on_out}, 12'd0);
    chk("rst_raddr", {4'd0, board_raddr}, 12'd0);
    reset = 1'b0; p_tick = 1'b0;
    fc = 6'd0; last_vs = 1'b1;
    push_inactive();

    for (int i = 0; i < vt.size(); i++)
      pix(vt[i].px, vt[i].py, vt[i].vo, vt[i].hs, vt[i].vs, vt[i].rgb, vt[i].addr, vt[i].nm);

    // mid-frame piece move: old shape stays until the next vsync fall
    piece_rows = {5'd6, 5'd5, 5'd25, 5'd6};
    pix(310, 165, 1'b1, 1'b1, 1'b0, 12'hF00, 54, "tear_old54");
    pix(310, 181, 1'b1, 1'b1, 1'b0, 12'h000, 64, "tear_old64");
    pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000, 0, "vs_high");
    pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 0, "vs_fall2");
    pix(310, 165, 1'b1, 1'b1, 1'b0, 12'hFF0, 54, "tear_new54");
    pix(310, 181, 1'b1, 1'b1, 1'b0, 12'hF00, 64, "tear_new64");

    // line-clear flash over 70 frames, crossing the frame counter wrap
    clear_rows = 20'd1 << 19;
    for (int f = 0; f < 70; f++) begin
      pix(0, 0, 1'b0, 1'b1, 1'b1, 12'h000, 0, "blink_vsh");
      pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 0, "blink_vsl");
      pix(250, 390, 1'b1, 1'b1, 1'b0, fc[3] ? 12'hFFF : 12'h000, 190, "blink");
    end

    // reset pulsed between pixels
    pix(355, 85, 1'b1, 1'b0, 1'b0, 12'hF80, 7, "pre_rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_hsync", {11'd0, hsync_out}, 12'd1);
    chk("mid_rst_vsync", {11'd0, vsync_out}, 12'd1);
    chk("mid_rst_vo", {11'd0, video_on_out}, 12'd0);
    chk("mid_rst_raddr", {4'd0, board_raddr}, 12'd0);
    reset = 1'b0;
    q.delete();
    push_inactive();
    fc = 6'd0; last_vs = 1'b1;
    pix(310, 165, 1'b1, 1'b1, 1'b1, 12'hFF0, 54, "rst_noshadow");
    pix(240, 80, 1'b1, 1'b0, 1'b1, 12'hF0F, 0, "rst_cell00");
    pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 0, "rst_vs_fall");
    pix(250, 390, 1'b1, 1'b1, 1'b0, fc[3] ? 12'hFFF : 12'h000, 190, "rst_blink");
    pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 0, "flush1");
    pix(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, 0, "flush2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
